pipelined_shifter: RTL and testbench
====================================

Name: pipelined_shifter

Overview:
Parametrised, pipelined barrel shifter. Supports logical left, logical right, arithmetic right, rotate left and rotate right on an N-bit operand. It processes one shift-amount bit per pipeline stage and uses a valid/ready handshake on input and output. It sits in the ALU datapath as the multi-cycle shift unit and sustains one result per clock at full throughput.

Parameters:
N, 32, operand/result width in bits; any value >= 2, power of two not required (N=11 must work)
S, $clog2(N), shift-amount width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  unit can accept a beat this cycle
in_a  input  N  operand
in_s  input  S  shift amount
in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass-through
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
out_y  output  N  shifted result
out_zero  output  1  out_y == 0

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, all stage data 0, out_valid=0, out_y=0, out_zero=1.
- Pipeline: S register stages. Stage k applies a shift of 2^k when bit k of the carried amount is set. Op, amount and sign bit travel with the data.
- Latency: a beat accepted at edge t appears on out_valid/out_y after edge t+S when there is no stall. For N=32 this is 5 cycles; for N=11 it is 4 cycles.
- Advance enable: adv = out_ready | ~out_valid. in_ready = adv, which is combinational from out_ready.
- Transfers: an input transfer happens when in_valid & in_ready. An output transfer happens when out_valid & out_ready.
- When adv=1, all stages shift forward in one step. Bubbles (valid=0) propagate like data, and bubbles are squeezed out only at the output stage.
- Stall: when out_valid & ~out_ready, every stage holds. out_y and out_zero stay stable and in_ready=0.
- Amounts >= N (reachable only when N is not a power of two):
  - SLL/SRL give all zeros.
  - SRA gives all copies of in_a[N-1].
  - ROL/ROR use in_s mod N, reduced in the input stage before stage 0.
- SRA fills with the sign bit captured at input, i.e. in_a[N-1].
- Rotates wrap the vacated bits from the opposite end within N bits. No bits are lost.
- Pass-through ops return in_a unchanged, with the same latency as every other op.
- in_s = 0 returns in_a for every op.
- Reset mid-operation: all in-flight beats are discarded and no partial result is emitted. The first beat after reset release sees the full latency.
- Ordering: results leave in strict acceptance order. No beat is duplicated or dropped under any out_ready pattern.
- Inputs are ignored when in_valid=0, and the bench may drive X on the data inputs then.

Test Plan:
- N=32, SLL in_a=0x0000_00F1 in_s=4, out_ready=1 -> out_y=0x0000_0F10 exactly 5 cycles after acceptance, out_zero=0.
- N=11:
  - SRA in_a=11'b100_0000_0000 in_s=3 -> 11'b111_1000_0000.
  - SRL same operand -> 11'b000_1000_0000.
  - SRA in_s=13 -> 11'b111_1111_1111; SRL in_s=13 -> 0 with out_zero=1.
  - ROL in_a=11'b100_0000_0001 in_s=12 (reduced to 1) -> 11'b000_0000_0011.
  - ROR same operand, in_s=1 -> 11'b110_0000_0000.
- Back-to-back random stream of 1024 beats (random a, s, op) with out_ready toggling randomly at about 50%:
  - Every out_y matches a behavioural model (<<, >>, >>>, rotate) in order.
  - Count out = count in; out_y is stable during stalls.
- Drop rst_n low with 3 beats in flight, release 2 cycles later:
  - out_valid=0 and out_y=0 immediately on assertion, and no stale beat ever appears.
  - The next beat emerges after the full latency.
- in_op=3'b111 with in_a=0x1234_5678, in_s=7 -> out_y=0x1234_5678. in_s=0 for all five ops returns in_a unchanged.

Source files
------------

// File: rtl/pipelined_shifter.sv
`default_nettype none
// ============================================================================
// Module     : pipelined_shifter
// Description: Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR/pass-through).
//              An input register reduces rotate amounts mod N, then S stages
//              each apply a conditional shift of 2^k. Valid/ready handshake
//              with a single global advance enable.
// Revision   : 1.0 - initial release
// ============================================================================
module pipelined_shifter #(
  parameter int N = 32,
  localparam int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [S-1:0] in_s,
  input  logic [2:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_y,
  output logic         out_zero
);

  localparam logic [2:0] c_op_sll = 3'b000;
  localparam logic [2:0] c_op_srl = 3'b001;
  localparam logic [2:0] c_op_sra = 3'b010;
  localparam logic [2:0] c_op_rol = 3'b011;
  localparam logic [2:0] c_op_ror = 3'b100;

  // N as an (S+1)-bit value; N itself may not fit in S bits
  localparam logic [S:0] c_n = N[S:0];

  // One conditional shift step of a fixed distance sh (always < N).
  // Logical shifts past N accumulate to zero, SRA accumulates to the sign.
  function automatic logic [N-1:0] shift_step(input logic [N-1:0] d,
                                              input logic [2:0]   op,
                                              input logic         sgn,
                                              input int           sh);
    logic [2*N-1:0] w_wide;
    w_wide     = '0;
    shift_step = d;
    case (op)
      c_op_sll: shift_step = d << sh;
      c_op_srl: shift_step = d >> sh;
      c_op_sra: begin
        w_wide     = {{N{sgn}}, d} >> sh;
        shift_step = w_wide[N-1:0];
      end
      c_op_rol: begin
        w_wide     = {d, d} << sh;
        shift_step = w_wide[2*N-1:N];
      end
      c_op_ror: begin
        w_wide     = {d, d} >> sh;
        shift_step = w_wide[N-1:0];
      end
      default:  shift_step = d;
    endcase
  endfunction

  // Index 0 is the input register; index k+1 holds the result of stage k.
  logic         r_vld [0:S];
  logic [N-1:0] r_dat [0:S];
  // Amount is consumed LSB-first: stage k always tests bit 0.
  logic [S-1:0] r_amt [0:S-1];
  logic [2:0]   r_op  [0:S-1];
  logic         r_sgn [0:S-1];
  logic         r_zero;

  logic         w_adv;
  logic         w_is_rot;
  logic [S-1:0] w_s_mod;
  logic [S-1:0] w_s_eff;
  logic         w_unused_amt;

  // Whole pipe moves together unless the output beat is stalled
  assign w_adv     = out_ready | ~r_vld[S];
  assign in_ready  = w_adv;
  assign out_valid = r_vld[S];
  assign out_y     = r_dat[S];
  assign out_zero  = r_zero;

  // in_s < 2^S < 2N, so a single conditional subtract gives in_s mod N
  assign w_s_mod  = ({1'b0, in_s} >= c_n) ? (in_s - c_n[S-1:0]) : in_s;
  assign w_is_rot = (in_op == c_op_rol) || (in_op == c_op_ror);
  assign w_s_eff  = w_is_rot ? w_s_mod : in_s;

  // Upper amount bits are already consumed by the last stage
  assign w_unused_amt = ^r_amt[S-1];

  // Input register: capture operand, reduced amount, op and sign bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld[0] <= 1'b0;
      r_dat[0] <= '0;
      r_amt[0] <= '0;
      r_op[0]  <= '0;
      r_sgn[0] <= 1'b0;
    end else if (w_adv) begin
      r_vld[0] <= in_valid;
      if (in_valid) begin
        r_dat[0] <= in_a;
        r_amt[0] <= w_s_eff;
        r_op[0]  <= in_op;
        r_sgn[0] <= in_a[N-1];
      end
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    logic [N-1:0] w_next;

    assign w_next = r_amt[k][0] ? shift_step(r_dat[k], r_op[k], r_sgn[k], 1 << k)
                                : r_dat[k];

    // Stage k: conditionally shift by 2^k; bubbles move like data
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld[k+1] <= 1'b0;
        r_dat[k+1] <= '0;
      end else if (w_adv) begin
        r_vld[k+1] <= r_vld[k];
        r_dat[k+1] <= w_next;
      end
    end

    if (k < S-1) begin : g_carry
      // Carry op, sign and remaining amount bits to the next stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_amt[k+1] <= '0;
          r_op[k+1]  <= '0;
          r_sgn[k+1] <= 1'b0;
        end else if (w_adv) begin
          r_amt[k+1] <= r_amt[k] >> 1;
          r_op[k+1]  <= r_op[k];
          r_sgn[k+1] <= r_sgn[k];
        end
      end
    end else begin : g_last
      // Zero flag registered alongside the final result
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_zero <= 1'b1;
        end else if (w_adv) begin
          r_zero <= ~|w_next;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
`default_nettype none
// ============================================================================
// Module     : tb_pipelined_shifter
// Description: Scoreboard bench for pipelined_shifter at N=32 and N=11.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_pipelined_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  iv = 2'b00, ir, ov, oz;
  logic [1:0]  ordy = 2'b11;
  logic [2:0]  iop0 = '0, iop1 = '0;
  logic [31:0] a32 = '0, y32;
  logic [4:0]  s32 = '0;
  logic [10:0] a11 = '0, y11;
  logic [3:0]  s11 = '0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [1:0]  acc = 2'b00;
  int          n_in[2];
  int          n_out[2];
  int          sent[2];
  int          tgt[2];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  pipelined_shifter #(.N(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_a(a32), .in_s(s32), .in_op(iop0),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_y(y32), .out_zero(oz[0])
  );

  pipelined_shifter #(.N(11)) u_dut11 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_a(a11), .in_s(s11), .in_op(iop1),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_y(y11), .out_zero(oz[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour on a w-bit operand held in 32 bits
  function automatic logic [31:0] model(input logic [31:0] a_in, input int s,
                                        input logic [2:0] op, input int w);
    logic [31:0] mask, a, r;
    logic        sg;
    int          sr;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    a    = a_in & mask;
    sg   = a[w-1];
    sr   = s % w;
    case (op)
      3'd0:    r = (s >= w) ? 32'd0 : ((a << s) & mask);
      3'd1:    r = (s >= w) ? 32'd0 : (a >> s);
      3'd2:    r = (s >= w) ? (sg ? mask : 32'd0)
                            : ((a >> s) | (sg ? (mask & ~(mask >> s)) : 32'd0));
      3'd3:    r = (sr == 0) ? a : (((a << sr) | (a >> (w - sr))) & mask);
      3'd4:    r = (sr == 0) ? a : (((a >> sr) | (a << (w - sr))) & mask);
      default: r = a;
    endcase
    return r;
  endfunction

  task automatic drive(input int d, input logic [31:0] a, input int s, input logic [2:0] op);
    if (d == 0) begin
      a32 = a; s32 = s[4:0]; iop0 = op; iv[0] = 1'b1;
    end else begin
      a11 = a[10:0]; s11 = s[3:0]; iop1 = op; iv[1] = 1'b1;
    end
  endtask

  task automatic rand_beat(input int d);
    drive(d, $urandom(), $urandom_range(0, (d != 0) ? 15 : 31), 3'($urandom_range(0, 7)));
  endtask

  // Output side: compare head of queue on every valid cycle (covers stalls),
  // pop on transfer; input side: push model result on transfer.
  task automatic mon(input int d);
    logic [31:0] y, e, a;
    int          s, w;
    logic [2:0]  op;
    if (!rst_n) return;
    y  = (d != 0) ? {21'd0, y11} : y32;
    a  = (d != 0) ? {21'd0, a11} : a32;
    s  = (d != 0) ? int'(s11) : int'(s32);
    op = (d != 0) ? iop1 : iop0;
    w  = (d != 0) ? 11 : 32;
    if (ov[d]) begin
      if ((d == 0 && q0.size() == 0) || (d != 0 && q1.size() == 0)) begin
        check((d != 0) ? "spurious11" : "spurious32", 32'd1, 32'd0);
      end else begin
        e = (d != 0) ? q1[0] : q0[0];
        check((d != 0) ? "y11" : "y32", y, e);
        check((d != 0) ? "zero11" : "zero32", {31'd0, oz[d]}, {31'd0, e == 32'd0});
        if (ordy[d]) begin
          if (d != 0) void'(q1.pop_front()); else void'(q0.pop_front());
          n_out[d]++;
        end
      end
    end
    if (iv[d] && ir[d]) begin
      if (d != 0) q1.push_back(model(a, s, op, w)); else q0.push_back(model(a, s, op, w));
      n_in[d]++;
      acc[d] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Single beat with out_ready held high: check latency, value and zero flag
  task automatic send(input int d, input logic [31:0] a, input int s, input logic [2:0] op,
                      input logic [31:0] exp, input string tag);
    int lat;
    int want;
    want = (d != 0) ? 4 : 5;
    @(posedge clk); #1;
    drive(d, a, s, op);
    @(posedge clk); #1;
    iv[d] = 1'b0;
    lat = 0;
    while (!ov[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(want));
    check(tag, (d != 0) ? {21'd0, y11} : y32, exp);
    check({tag, "_zero"}, {31'd0, oz[d]}, {31'd0, exp == 32'd0});
  endtask

  initial begin
    int cyc;
    n_in[0] = 0; n_in[1] = 0; n_out[0] = 0; n_out[1] = 0;

    // Reset state
    #12;
    check("rst_valid", {30'd0, ov}, 32'd0);
    check("rst_y32", y32, 32'd0);
    check("rst_y11", {21'd0, y11}, 32'd0);
    check("rst_zero", {30'd0, oz}, 32'd3);
    check("rst_ready", {30'd0, ir}, 32'd3);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vectors
    send(0, 32'h0000_00F1, 4, 3'b000, 32'h0000_0F10, "sll32");
    send(1, 32'h400, 3,  3'b010, 32'h780, "sra11");
    send(1, 32'h400, 3,  3'b001, 32'h080, "srl11");
    send(1, 32'h400, 13, 3'b010, 32'h7FF, "sra11_big");
    send(1, 32'h400, 13, 3'b001, 32'h000, "srl11_big");
    send(1, 32'h401, 12, 3'b011, 32'h003, "rol11_mod");
    send(1, 32'h401, 1,  3'b100, 32'h600, "ror11");
    send(0, 32'h1234_5678, 7, 3'b111, 32'h1234_5678, "pass32");
    for (int op = 0; op < 5; op++) begin
      send(0, 32'h8765_4321, 0, 3'(op), 32'h8765_4321, "s0_32");
      send(1, 32'h5A5, 0, 3'(op), 32'h5A5, "s0_11");
    end

    // Reset with three beats in flight
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive(0, $urandom() | 32'h1, $urandom_range(0, 31), 3'($urandom_range(0, 7)));
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, ov[0]}, 32'd0);
    check("rst_mid_y", y32, 32'd0);
    check("rst_mid_zero", {31'd0, oz[0]}, 32'd1);
    q0.delete();
    q1.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    send(0, 32'h0000_0ABC, 0, 3'b000, 32'h0000_0ABC, "post_rst");

    // Random back-to-back stream with random backpressure
    @(posedge clk); #1;
    acc = 2'b00;
    n_in[0] = 0; n_in[1] = 0; n_out[0] = 0; n_out[1] = 0;
    sent[0] = 0; sent[1] = 0;
    tgt[0] = 256; tgt[1] = 1024;
    rand_beat(0);
    rand_beat(1);
    cyc = 0;
    while ((sent[0] < tgt[0] || sent[1] < tgt[1]) && cyc < 20000) begin
      ordy[0] = 1'($urandom_range(0, 1));
      ordy[1] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (acc[d]) begin
          acc[d] = 1'b0;
          sent[d]++;
          if (sent[d] < tgt[d]) rand_beat(d);
          else iv[d] = 1'b0;
        end
      end
    end
    check("stream_done", {31'd0, cyc < 20000}, 32'd1);

    // Drain and account
    ordy = 2'b11;
    cyc = 0;
    while ((q0.size() != 0 || q1.size() != 0) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain32", 32'(q0.size()), 32'd0);
    check("drain11", 32'(q1.size()), 32'd0);
    check("count32", 32'(n_out[0]), 32'(n_in[0]));
    check("count11", 32'(n_out[1]), 32'(n_in[1]));
    check("in11", 32'(n_in[1]), 32'd1024);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
